cp0_exc_sequencer: RTL
======================

# cp0_exc_sequencer

Commit-side controller that owns the single CP0 write port. It turns a committed exception or ERET into an ordered sequence of CP0 register writes: EPC, BadVAddr, Cause, then Status. It then issues one front-end redirect. Between sequences it grants the port to the ALU's MTC0 requests. It sits between the commit/exception logic and CP0's write interface, and reads the current CP0 state through the status-register bundle.

## Interface
- No parameters.
- `clk`  in  1  system clock.
- `rst`  in  1  synchronous, active-high reset.
- `exc_valid`  in  1  committed exception request; held until accepted.
- `exc_ready`  out  1  exception accepted this cycle (`exc_valid && state==IDLE`).
- `exc_code`  in  5  MIPS ExcCode.
- `exc_pc`  in  32  PC of the faulting instruction.
- `exc_bd`  in  1  faulting instruction is in a delay slot.
- `exc_badvaddr`  in  32  faulting address (AdEL/AdES only).
- `eret_valid`  in  1  committed ERET; held until accepted.
- `eret_ready`  out  1  ERET accepted this cycle.
- `mtc0_valid`, `mtc0_addr[4:0]`, `mtc0_sel[2:0]`, `mtc0_data[31:0]`  in  ALU MTC0 request.
- `mtc0_ready`  out  1  MTC0 forwarded to the port this cycle.
- `cp0_status`, `cp0_cause`, `cp0_epc`, `cp0_ebase`, `cp0_errorepc`  in  32 each  current CP0 values.
- `cp0_we`  out  1  CP0 write enable.
- `cp0_addr`  out  5  CP0 write address.
- `cp0_sel`  out  3  CP0 write select.
- `cp0_wdata`  out  32  CP0 write data.
- `redirect_valid`  out  1  one-cycle pulse; front end fetches from `redirect_pc`.
- `redirect_pc`  out  32  redirect target.
- `busy`  out  1  state ≠ IDLE.

## Operation
- **States:** IDLE, EPC, BADV, CAUSE, STAT, REDIR, ERET_STAT, ERET_REDIR.
- **IDLE priority:** exception > ERET > MTC0.
  - Only one request is accepted per cycle.
  - `mtc0_ready = mtc0_valid && !exc_valid && !eret_valid` in IDLE, and 0 in every other state.
  - When MTC0 is granted, the port is driven combinationally from the mtc0 inputs in the same cycle.
- **Snapshot on accept:** status, cause, ebase, epc, errorepc, code, pc, bd, badvaddr are captured into registers. All later writes are computed from the snapshot, never from the live inputs.
- **Exception path:** IDLE → EPC → BADV → CAUSE → STAT → REDIR → IDLE. One write per state.
  - **EPC:** writes `bd ? pc-4 : pc` (32-bit wrap). Skipped if snap Status.EXL=1; the port is idle that cycle and no write occurs.
  - **BADV:** writes badvaddr to address 8. Only for exc_code 4 or 5; otherwise the port is idle that cycle.
  - **CAUSE:** writes `{BD, cause[30:7], code, cause[1:0]}`. BD is `exc_bd`, or the snapshot's BD if EXL was already 1.
  - **STAT:** writes snap status with bit 1 (EXL) set.
  - **REDIR:** asserts `redirect_valid`.
    - `redirect_pc` = 0xBFC00380 if snap Status.BEV(22)=1.
    - Otherwise `{ebase[31:12], 12'h180}`.
- **ERET path:** IDLE → ERET_STAT → ERET_REDIR → IDLE.
  - If snap ERL(2)=1: clear ERL; target = errorepc.
  - Otherwise: clear EXL(1); target = epc.
- **Port encoding:** `cp0_we` is high only in write states and on MTC0 grant. All writes are full 32-bit; CP0 applies its own writable masks.
- **Reset:** forces IDLE and all outputs to 0 (`cp0_*`, `redirect_*`, `busy`, `*_ready`). A sequence in progress is abandoned with no further writes and no redirect.

## Timing
- Accept at cycle T.
- Exception: EPC write at T+1, BADV at T+2, CAUSE at T+3, STAT at T+4, `redirect_valid` at T+5. The next request can be accepted at T+6.
- ERET: Status write at T+1, redirect at T+2, next accept at T+3.
- Fixed latency: every slot is spent even when its write is skipped.
- MTC0: zero latency. The write occurs in the grant cycle; CP0 register updates at T+1.
- `exc_valid` and `eret_valid` high together in IDLE: the exception is accepted. ERET stays pending and is accepted at T+6 if still valid.
- Requests arriving while busy are not acknowledged; the requester holds them.

## Configuration
- `CP0_SEQ_BADVADDR_EN` defined: BADV state present; the exception redirect is at T+5.
- Not defined:
  - BADV state removed and `exc_badvaddr` ignored.
  - Sequence is EPC → CAUSE → STAT → REDIR, with the redirect at T+4.
  - Address 8 is never written by this block.

## Structure
- **Shared package:** state enum, ExcCode constants (Int=0, AdEL=4, AdES=5, Sys=8, Bp=9, RI=10, Ov=12), Status bit indices (EXL, ERL, BEV), and the vector constants 0xBFC00380 and 0x180.
- **CP0 addresses:** use the existing `CP0*` macros from `defines.svh`.
- **Sub-module:** `exc_vector_calc`, pure combinational. Inputs are snap status and ebase; output is the exception target.

## Test plan
- **Sys exception**, pc=0x80001000, bd=0, status=0x00000000, ebase=0x80000000:
  - Writes EPC=0x80001000, Cause[6:2]=8, Status=0x00000002.
  - Redirect 0x80000180 at T+5.
- **AdEL**, bd=1, pc=0x80002004, badvaddr=0x00000003, BEV=1:
  - EPC=0x80002000, BadVAddr=3, Cause[31]=1.
  - Redirect 0xBFC00380.
- **Exception with snap EXL=1:** no write at T+1; Cause ExcCode updated with BD preserved.
- **ERET with ERL=1**, errorepc=0xBFC00100: Status bit 2 cleared at T+1; redirect 0xBFC00100 at T+2.
- **exc + eret + mtc0 asserted together in IDLE:**
  - Exception accepted; `mtc0_ready`=0 through T+5.
  - ERET accepted at T+6.
  - MTC0 granted after the ERET completes.
- **`rst` asserted at T+2 of an exception:** no CAUSE or STAT write and no redirect. All outputs are 0 the cycle after reset.

Source files
------------

// File: rtl/cp0_exc_sequencer_pkg.sv
// ============================================================================
// Module   : cp0_exc_sequencer_pkg
// Brief    : Shared types and constants for the CP0 exception write sequencer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package cp0_exc_sequencer_pkg;

    typedef enum logic [3:0] {
        S_IDLE       = 4'd0,
        S_EPC        = 4'd1,
        S_BADV       = 4'd2,
        S_CAUSE      = 4'd3,
        S_STAT       = 4'd4,
        S_REDIR      = 4'd5,
        S_ERET_STAT  = 4'd6,
        S_ERET_REDIR = 4'd7
    } state_t;

    localparam logic [4:0] c_EXC_INT  = 5'd0;
    localparam logic [4:0] c_EXC_ADEL = 5'd4;
    localparam logic [4:0] c_EXC_ADES = 5'd5;
    localparam logic [4:0] c_EXC_SYS  = 5'd8;
    localparam logic [4:0] c_EXC_BP   = 5'd9;
    localparam logic [4:0] c_EXC_RI   = 5'd10;
    localparam logic [4:0] c_EXC_OV   = 5'd12;

    localparam int c_STATUS_EXL = 1;
    localparam int c_STATUS_ERL = 2;
    localparam int c_STATUS_BEV = 22;

    localparam logic [31:0] c_BEV_VECTOR   = 32'hBFC0_0380;
    localparam logic [11:0] c_GEN_OFFSET   = 12'h180;

    localparam logic [4:0] c_CP0_BADVADDR = 5'd8;
    localparam logic [4:0] c_CP0_STATUS   = 5'd12;
    localparam logic [4:0] c_CP0_CAUSE    = 5'd13;
    localparam logic [4:0] c_CP0_EPC      = 5'd14;
    localparam logic [2:0] c_CP0_SEL0     = 3'd0;

    function automatic logic is_addr_exc(input logic [4:0] code);
        return (code == c_EXC_ADEL) || (code == c_EXC_ADES);
    endfunction

endpackage

`default_nettype wire

// File: rtl/exc_vector_calc.sv
// ============================================================================
// Module   : exc_vector_calc
// Brief    : Combinational exception vector selection from Status.BEV / EBase.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module exc_vector_calc
    import cp0_exc_sequencer_pkg::*;
(
    input  logic [31:0] status,
    input  logic [31:0] ebase,
    output logic [31:0] vector
);

    logic w_unused;

    assign vector   = status[c_STATUS_BEV] ? c_BEV_VECTOR : {ebase[31:12], c_GEN_OFFSET};
    assign w_unused = &{1'b0, status[31:23], status[21:0], ebase[11:0]};

endmodule

`default_nettype wire

// File: rtl/cp0_exc_sequencer.sv
// ============================================================================
// Module   : cp0_exc_sequencer
// Brief    : Owns the CP0 write port; sequences exception/ERET writes and MTC0.
//            Optional BadVAddr write slot enabled by CP0_SEQ_BADVADDR_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cp0_exc_sequencer
    import cp0_exc_sequencer_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        exc_valid,
    output logic        exc_ready,
    input  logic [4:0]  exc_code,
    input  logic [31:0] exc_pc,
    input  logic        exc_bd,
    input  logic [31:0] exc_badvaddr,
    input  logic        eret_valid,
    output logic        eret_ready,
    input  logic        mtc0_valid,
    input  logic [4:0]  mtc0_addr,
    input  logic [2:0]  mtc0_sel,
    input  logic [31:0] mtc0_data,
    output logic        mtc0_ready,
    input  logic [31:0] cp0_status,
    input  logic [31:0] cp0_cause,
    input  logic [31:0] cp0_epc,
    input  logic [31:0] cp0_ebase,
    input  logic [31:0] cp0_errorepc,
    output logic        cp0_we,
    output logic [4:0]  cp0_addr,
    output logic [2:0]  cp0_sel,
    output logic [31:0] cp0_wdata,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    output logic        busy
);

    state_t      r_state, w_next;
    logic [31:0] r_status, r_cause, r_ebase, r_epc, r_errorepc, r_pc;
    logic [4:0]  r_code;
    logic        r_bd;
`ifdef CP0_SEQ_BADVADDR_EN
    logic [31:0] r_badvaddr;
`endif
    logic        w_idle, w_exc_acc, w_eret_acc, w_mtc0_acc;
    logic        w_cause_bd;
    logic [31:0] w_exc_vector, w_exc_status, w_eret_status;
    logic        w_unused;

    assign w_idle     = (r_state == S_IDLE) && !rst;
    assign w_exc_acc  = w_idle && exc_valid;
    assign w_eret_acc = w_idle && eret_valid && !exc_valid;
    assign w_mtc0_acc = w_idle && mtc0_valid && !exc_valid && !eret_valid;

    assign exc_ready  = w_exc_acc;
    assign eret_ready = w_eret_acc;
    assign mtc0_ready = w_mtc0_acc;
    assign busy       = (r_state != S_IDLE) && !rst;

    // A nested exception keeps the BD recorded by the original one.
    assign w_cause_bd = r_status[c_STATUS_EXL] ? r_cause[31] : r_bd;

    always_comb begin
        w_exc_status = r_status;
        w_exc_status[c_STATUS_EXL] = 1'b1;
        w_eret_status = r_status;
        if (r_status[c_STATUS_ERL]) w_eret_status[c_STATUS_ERL] = 1'b0;
        else                        w_eret_status[c_STATUS_EXL] = 1'b0;
    end

    exc_vector_calc u_vector (
        .status (r_status),
        .ebase  (r_ebase),
        .vector (w_exc_vector)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_status   <= '0;
            r_cause    <= '0;
            r_ebase    <= '0;
            r_epc      <= '0;
            r_errorepc <= '0;
            r_pc       <= '0;
            r_code     <= '0;
            r_bd       <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_exc_acc || w_eret_acc) begin
                r_status   <= cp0_status;
                r_cause    <= cp0_cause;
                r_ebase    <= cp0_ebase;
                r_epc      <= cp0_epc;
                r_errorepc <= cp0_errorepc;
                r_pc       <= exc_pc;
                r_code     <= exc_code;
                r_bd       <= exc_bd;
            end
        end
    end

`ifdef CP0_SEQ_BADVADDR_EN
    always_ff @(posedge clk) begin
        if (rst)                          r_badvaddr <= '0;
        else if (w_exc_acc || w_eret_acc) r_badvaddr <= exc_badvaddr;
    end
    assign w_unused = &{1'b0, r_cause[6:2]};
`else
    assign w_unused = &{1'b0, r_cause[6:2], exc_badvaddr};
`endif

    always_comb begin
        w_next         = r_state;
        cp0_we         = 1'b0;
        cp0_addr       = '0;
        cp0_sel        = '0;
        cp0_wdata      = '0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        case (r_state)
            S_IDLE: begin
                if (w_exc_acc)       w_next = S_EPC;
                else if (w_eret_acc) w_next = S_ERET_STAT;
                else if (w_mtc0_acc) begin
                    cp0_we    = 1'b1;
                    cp0_addr  = mtc0_addr;
                    cp0_sel   = mtc0_sel;
                    cp0_wdata = mtc0_data;
                end
            end
            S_EPC: begin
                if (!r_status[c_STATUS_EXL]) begin
                    cp0_we    = 1'b1;
                    cp0_addr  = c_CP0_EPC;
                    cp0_sel   = c_CP0_SEL0;
                    cp0_wdata = r_bd ? (r_pc - 32'd4) : r_pc;
                end
`ifdef CP0_SEQ_BADVADDR_EN
                w_next = S_BADV;
`else
                w_next = S_CAUSE;
`endif
            end
            S_BADV: begin
`ifdef CP0_SEQ_BADVADDR_EN
                if (is_addr_exc(r_code)) begin
                    cp0_we    = 1'b1;
                    cp0_addr  = c_CP0_BADVADDR;
                    cp0_sel   = c_CP0_SEL0;
                    cp0_wdata = r_badvaddr;
                end
`endif
                w_next = S_CAUSE;
            end
            S_CAUSE: begin
                cp0_we    = 1'b1;
                cp0_addr  = c_CP0_CAUSE;
                cp0_sel   = c_CP0_SEL0;
                cp0_wdata = {w_cause_bd, r_cause[30:7], r_code, r_cause[1:0]};
                w_next    = S_STAT;
            end
            S_STAT: begin
                cp0_we    = 1'b1;
                cp0_addr  = c_CP0_STATUS;
                cp0_sel   = c_CP0_SEL0;
                cp0_wdata = w_exc_status;
                w_next    = S_REDIR;
            end
            S_REDIR: begin
                redirect_valid = 1'b1;
                redirect_pc    = w_exc_vector;
                w_next         = S_IDLE;
            end
            S_ERET_STAT: begin
                cp0_we    = 1'b1;
                cp0_addr  = c_CP0_STATUS;
                cp0_sel   = c_CP0_SEL0;
                cp0_wdata = w_eret_status;
                w_next    = S_ERET_REDIR;
            end
            S_ERET_REDIR: begin
                redirect_valid = 1'b1;
                redirect_pc    = r_status[c_STATUS_ERL] ? r_errorepc : r_epc;
                w_next         = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
        // An abandoned sequence must not leak a write or redirect in the reset cycle.
        if (rst) begin
            cp0_we         = 1'b0;
            cp0_addr       = '0;
            cp0_sel        = '0;
            cp0_wdata      = '0;
            redirect_valid = 1'b0;
            redirect_pc    = '0;
        end
    end

endmodule

`default_nettype wire
